// File: rtl/mcu_rocstar_port_if.sv
// Command and readback bundle between the bus logic (master) and one rocstar port (slave).
interface mcu_rocstar_port_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_code;
   logic [15:0] cmd_data;
   logic        rx_valid;
   logic [1:0]  rx_tag;
   logic [15:0] rx_data;
   logic        rx_err;

   modport master (
      output cmd_valid, cmd_code, cmd_data,
      input  cmd_ready, rx_valid, rx_tag, rx_data, rx_err
   );

   modport slave (
      input  cmd_valid, cmd_code, cmd_data,
      output cmd_ready, rx_valid, rx_tag, rx_data, rx_err
   );
endinterface

// File: rtl/mcu_rocstar_port.sv
// MCU-side endpoint of one rocstar link: 4-bit command downlink serializer, 8-bit uplink deframer.
// Optional single-hit counter enabled by defining MCU_PORT_SINGLE_CTR_EN.
module mcu_rocstar_port #(
   parameter int GAP_CYCLES     = 1,
   parameter int SPWORD_NIBBLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mcu_rocstar_port_if.slave   bus,
   output logic [3:0]          to_rocstar,
   input  logic [7:0]          from_rocstar,
   output logic                single,
   input  logic                cnt_clr,
   output logic [31:0]         single_cnt
);

   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_HDR = 2'd1, TX_NIB = 2'd2, TX_GAP = 2'd3} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_S1 = 2'd1, RX_S2 = 2'd2} rx_state_t;

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
   localparam logic [3:0] NIB_LAST = 4'(SPWORD_NIBBLES - 1);

   tx_state_t   tx_state_r, tx_state_nxt_s;
   logic [3:0]  tx_cnt_r, tx_cnt_nxt_s;
   logic [2:0]  code_r, code_nxt_s;
   logic [15:0] data_r, data_nxt_s;
   logic [3:0]  tx_sym_s, to_rocstar_r;
   logic        ready_nxt_s, cmd_ready_r, accept_s;

   // cmd_ready_r is only ever high in TX_IDLE, so it alone qualifies acceptance
   assign accept_s   = bus.cmd_valid & cmd_ready_r;
   assign code_nxt_s = accept_s ? bus.cmd_code : code_r;
   assign data_nxt_s = accept_s ? bus.cmd_data : data_r;

   // TX state, counter and latched command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= 4'd0;
         code_r     <= 3'd0;
         data_r     <= 16'h0000;
      end else begin
         tx_state_r <= tx_state_nxt_s;
         tx_cnt_r   <= tx_cnt_nxt_s;
         code_r     <= code_nxt_s;
         data_r     <= data_nxt_s;
      end
   end

   // TX next-state logic; tx_cnt counts nibbles in NIB and idle cycles in GAP
   always_comb begin
      tx_state_nxt_s = tx_state_r;
      tx_cnt_nxt_s   = 4'd0;
      case (tx_state_r)
         TX_IDLE: begin
            if (accept_s) tx_state_nxt_s = TX_HDR;
            else          tx_state_nxt_s = TX_IDLE;
         end
         TX_HDR: begin
            if (code_r == 3'd0) tx_state_nxt_s = TX_NIB;
            else                tx_state_nxt_s = TX_GAP;
         end
         TX_NIB: begin
            if (tx_cnt_r == NIB_LAST) tx_state_nxt_s = TX_GAP;
            else                      tx_cnt_nxt_s   = tx_cnt_r + 4'd1;
         end
         TX_GAP: begin
            if (tx_cnt_r == GAP_LAST) tx_state_nxt_s = TX_IDLE;
            else                      tx_cnt_nxt_s   = tx_cnt_r + 4'd1;
         end
         default: tx_state_nxt_s = TX_IDLE;
      endcase
   end

   // TX outputs decoded from the next state so the registered symbol lines up with it
   always_comb begin
      tx_sym_s    = 4'h0;
      ready_nxt_s = 1'b0;
      case (tx_state_nxt_s)
         TX_IDLE: ready_nxt_s = 1'b1;
         TX_HDR: begin
            if (code_nxt_s == 3'd0) tx_sym_s = 4'h8;
            else                    tx_sym_s = {1'b0, code_nxt_s};
         end
         TX_NIB: begin
            case (tx_cnt_nxt_s[1:0])
               2'd0:    tx_sym_s = data_nxt_s[15:12];
               2'd1:    tx_sym_s = data_nxt_s[11:8];
               2'd2:    tx_sym_s = data_nxt_s[7:4];
               2'd3:    tx_sym_s = data_nxt_s[3:0];
               default: tx_sym_s = 4'h0;
            endcase
         end
         TX_GAP:  tx_sym_s = 4'h0;
         default: tx_sym_s = 4'h0;
      endcase
   end

   // TX output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_rocstar_r <= 4'h0;
         cmd_ready_r  <= 1'b0;
      end else begin
         to_rocstar_r <= tx_sym_s;
         cmd_ready_r  <= ready_nxt_s;
      end
   end

   assign to_rocstar    = to_rocstar_r;
   assign bus.cmd_ready = cmd_ready_r;

   rx_state_t   rx_state_r, rx_state_nxt_s;
   logic [7:0]  in_q_r;
   logic [5:0]  pay_hi_r, pay_mid_r;
   logic        rx_valid_s, rx_err_s, ld_hi_s, ld_mid_s;
   logic        rx_valid_r, rx_err_r;
   logic [1:0]  rx_tag_r;
   logic [15:0] rx_data_r;

   // Uplink input register and RX state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q_r     <= 8'h00;
         rx_state_r <= RX_IDLE;
      end else begin
         in_q_r     <= from_rocstar;
         rx_state_r <= rx_state_nxt_s;
      end
   end

   // RX next-state logic; S2 always returns to IDLE so the next symbol may open a new frame
   always_comb begin
      rx_state_nxt_s = RX_IDLE;
      case (rx_state_r)
         RX_IDLE: begin
            if (in_q_r[6]) rx_state_nxt_s = RX_S1;
            else           rx_state_nxt_s = RX_IDLE;
         end
         RX_S1: begin
            if (in_q_r[6]) rx_state_nxt_s = RX_S2;
            else           rx_state_nxt_s = RX_IDLE;
         end
         RX_S2:   rx_state_nxt_s = RX_IDLE;
         default: rx_state_nxt_s = RX_IDLE;
      endcase
   end

   // RX output and payload-load decode
   always_comb begin
      rx_valid_s = 1'b0;
      rx_err_s   = 1'b0;
      ld_hi_s    = 1'b0;
      ld_mid_s   = 1'b0;
      case (rx_state_r)
         RX_IDLE: ld_hi_s = in_q_r[6];
         RX_S1: begin
            if (in_q_r[6]) ld_mid_s = 1'b1;
            else           rx_err_s = 1'b1;
         end
         RX_S2: begin
            if (in_q_r[6]) rx_valid_s = 1'b1;
            else           rx_err_s   = 1'b1;
         end
         default: rx_err_s = 1'b0;
      endcase
   end

   // RX payload assembly and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pay_hi_r   <= 6'h00;
         pay_mid_r  <= 6'h00;
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
         rx_tag_r   <= 2'd0;
         rx_data_r  <= 16'h0000;
      end else begin
         rx_valid_r <= rx_valid_s;
         rx_err_r   <= rx_err_s;
         if (ld_hi_s)  pay_hi_r  <= in_q_r[5:0];
         if (ld_mid_s) pay_mid_r <= in_q_r[5:0];
         if (rx_valid_s) begin
            rx_tag_r  <= pay_hi_r[5:4];
            rx_data_r <= {pay_hi_r[3:0], pay_mid_r, in_q_r[5:0]};
         end
      end
   end

   assign single       = in_q_r[7];
   assign bus.rx_valid = rx_valid_r;
   assign bus.rx_err   = rx_err_r;
   assign bus.rx_tag   = rx_tag_r;
   assign bus.rx_data  = rx_data_r;

`ifdef MCU_PORT_SINGLE_CTR_EN
   logic [31:0] single_cnt_r;

   // Saturating single-hit counter; clear takes priority over counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             single_cnt_r <= 32'h0000_0000;
      else if (cnt_clr)                       single_cnt_r <= 32'h0000_0000;
      else if (single && (single_cnt_r != 32'hFFFF_FFFF))
                                              single_cnt_r <= single_cnt_r + 32'd1;
   end

   assign single_cnt = single_cnt_r;
`else
   logic unused_clr_s;
   assign unused_clr_s = cnt_clr;
   assign single_cnt   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mcu_rocstar_port.sv
// Directed, table-driven bench for mcu_rocstar_port at GAP_CYCLES=1.
module tb_mcu_rocstar_port;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  from_rocstar;
   logic        cnt_clr;
   logic [3:0]  to_rocstar;
   logic        single;
   logic [31:0] single_cnt;

   mcu_rocstar_port_if bus();

   mcu_rocstar_port #(.GAP_CYCLES(1), .SPWORD_NIBBLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .to_rocstar   (to_rocstar),
      .from_rocstar (from_rocstar),
      .single       (single),
      .cnt_clr      (cnt_clr),
      .single_cnt   (single_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // inputs driven before an edge, outputs expected just after it
   typedef struct {
      logic        valid;
      logic [2:0]  code;
      logic [15:0] data;
      logic [7:0]  fr;
      logic [3:0]  e_sym;
      logic        e_rdy;
      logic        e_single;
      logic        e_rxv;
      logic        e_rxe;
      logic [1:0]  e_tag;
      logic [15:0] e_rdata;
   } vec_t;

   vec_t vecs[20];

   function automatic vec_t mk(logic v, logic [2:0] c, logic [15:0] d, logic [7:0] f,
                               logic [3:0] s, logic r, logic sg, logic rv, logic re,
                               logic [1:0] t, logic [15:0] rd);
      vec_t x;
      x.valid = v; x.code = c; x.data = d; x.fr = f;
      x.e_sym = s; x.e_rdy = r; x.e_single = sg; x.e_rxv = rv; x.e_rxe = re;
      x.e_tag = t; x.e_rdata = rd;
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             vld code data      fr     sym  rdy  sgl  rxv  rxe  tag   rdata
      vecs[0]  = mk(1'b0, 3'd0, 16'h0000, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
      vecs[1]  = mk(1'b1, 3'd3, 16'h0000, 8'h6F, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
      vecs[2]  = mk(1'b0, 3'd0, 16'h0000, 8'h7B, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
      vecs[3]  = mk(1'b0, 3'd0, 16'h0000, 8'h6A, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
      vecs[4]  = mk(1'b1, 3'd0, 16'hBEEF, 8'h80, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'hFEEA);
      vecs[5]  = mk(1'b1, 3'd1, 16'hBEEF, 8'h41, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'hFEEA);
      vecs[6]  = mk(1'b1, 3'd1, 16'hBEEF, 8'h42, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'hFEEA);
      vecs[7]  = mk(1'b1, 3'd1, 16'hBEEF, 8'h43, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'hFEEA);
      vecs[8]  = mk(1'b1, 3'd1, 16'hBEEF, 8'hFF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h1083);
      vecs[9]  = mk(1'b1, 3'd1, 16'hBEEF, 8'h40, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h1083);
      vecs[10] = mk(1'b1, 3'd1, 16'hBEEF, 8'h55, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h1083);
      vecs[11] = mk(1'b1, 3'd1, 16'hBEEF, 8'h00, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 16'hF015);
      vecs[12] = mk(1'b0, 3'd0, 16'h0000, 8'h6A, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 16'hF015);
      vecs[13] = mk(1'b0, 3'd0, 16'h0000, 8'h51, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 16'hF015);
      vecs[14] = mk(1'b1, 3'd7, 16'h0000, 8'h00, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 16'hF015);
      vecs[15] = mk(1'b1, 3'd2, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'hF015);
      vecs[16] = mk(1'b1, 3'd2, 16'h0000, 8'h41, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 16'hF015);
      vecs[17] = mk(1'b1, 3'd2, 16'h0000, 8'h80, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 16'hF015);
      vecs[18] = mk(1'b0, 3'd0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'hF015);
      vecs[19] = mk(1'b0, 3'd0, 16'h0000, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 16'hF015);

      rst_n         = 1'b0;
      from_rocstar  = 8'h00;
      cnt_clr       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_code  = 3'd0;
      bus.cmd_data  = 16'h0000;
      step();
      step();
      chk("reset to_rocstar", 32'(to_rocstar), 32'h0);
      chk("reset cmd_ready", 32'(bus.cmd_ready), 32'h0);
      chk("reset single", 32'(single), 32'h0);
      chk("reset rx_valid", 32'(bus.rx_valid), 32'h0);
      chk("reset rx_err", 32'(bus.rx_err), 32'h0);
      chk("reset rx_tag", 32'(bus.rx_tag), 32'h0);
      chk("reset rx_data", 32'(bus.rx_data), 32'h0);
      chk("reset single_cnt", single_cnt, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         bus.cmd_valid = vecs[i].valid;
         bus.cmd_code  = vecs[i].code;
         bus.cmd_data  = vecs[i].data;
         from_rocstar  = vecs[i].fr;
         step();
         chk($sformatf("v%0d to_rocstar", i), 32'(to_rocstar), 32'(vecs[i].e_sym));
         chk($sformatf("v%0d cmd_ready", i), 32'(bus.cmd_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d single", i), 32'(single), 32'(vecs[i].e_single));
         chk($sformatf("v%0d rx_valid", i), 32'(bus.rx_valid), 32'(vecs[i].e_rxv));
         chk($sformatf("v%0d rx_err", i), 32'(bus.rx_err), 32'(vecs[i].e_rxe));
         chk($sformatf("v%0d rx_tag", i), 32'(bus.rx_tag), 32'(vecs[i].e_tag));
         chk($sformatf("v%0d rx_data", i), 32'(bus.rx_data), 32'(vecs[i].e_rdata));
      end

      // reset in the middle of a spword, right after its second nibble
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = 3'd0;
      bus.cmd_data  = 16'hA5C3;
      step();
      chk("mid hdr", 32'(to_rocstar), 32'h8);
      bus.cmd_valid = 1'b0;
      step();
      chk("mid nib1", 32'(to_rocstar), 32'hA);
      step();
      chk("mid nib2", 32'(to_rocstar), 32'h5);
      rst_n = 1'b0;
      #1;
      chk("mid rst to_rocstar", 32'(to_rocstar), 32'h0);
      chk("mid rst cmd_ready", 32'(bus.cmd_ready), 32'h0);
      chk("mid rst rx_data", 32'(bus.rx_data), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("in rst %0d to_rocstar", k), 32'(to_rocstar), 32'h0);
      end
      rst_n = 1'b1;
      #2;
      chk("post rel cmd_ready", 32'(bus.cmd_ready), 32'h0);
      step();
      chk("first edge cmd_ready", 32'(bus.cmd_ready), 32'h1);
      chk("first edge to_rocstar", 32'(to_rocstar), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("after rst %0d to_rocstar", k), 32'(to_rocstar), 32'h0);
      end

`ifdef MCU_PORT_SINGLE_CTR_EN
      from_rocstar = 8'h80;
      for (int k = 0; k < 5; k++) step();
      from_rocstar = 8'h00;
      step();
      step();
      chk("single_cnt five", single_cnt, 32'd5);
      from_rocstar = 8'h80;
      cnt_clr      = 1'b1;
      step();
      step();
      chk("single_cnt clr wins", single_cnt, 32'd0);
      cnt_clr      = 1'b0;
      from_rocstar = 8'h00;
      step();
      step();
      chk("single_cnt after clr", single_cnt, 32'd1);
`else
      from_rocstar = 8'h80;
      for (int k = 0; k < 3; k++) step();
      from_rocstar = 8'h00;
      step();
      chk("single_cnt tied off", single_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
